// File: rtl/hc74_arbiter.sv
// Two-requester round-robin arbiter that sequences SET/CLEAR/LOAD operations
// onto a pair of external flip-flops and keeps a shadow copy of their state.
module hc74_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic       req1,
    input  logic       req2,
    input  logic [1:0] cmd1,
    input  logic [1:0] cmd2,
    input  logic       sel1,
    input  logic       sel2,
    input  logic       din1,
    input  logic       din2,
    output logic       gnt1,
    output logic       gnt2,
    output logic       ack1,
    output logic       ack2,
    output logic [1:0] s_n,
    output logic [1:0] r_n,
    output logic [1:0] d,
    output logic [1:0] clk_en,
    output logic [1:0] q,
    output logic       busy
);

    localparam logic [1:0] CMD_NOP  = 2'b00;
    localparam logic [1:0] CMD_SET  = 2'b01;
    localparam logic [1:0] CMD_CLR  = 2'b10;
    localparam logic [1:0] CMD_LOAD = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GRANT = 2'b01,
        DRIVE = 2'b10,
        DONE  = 2'b11
    } state_t;

    function automatic logic [1:0] sel_mask(input logic sel);
        return sel ? 2'b10 : 2'b01;
    endfunction

    state_t     state_r, state_s;
    logic       ptr_r, ptr_s;
    logic       arb_s;
    logic       owner_s;
    logic       win_r;
    logic [1:0] op_cmd_r;
    logic       op_sel_r;
    logic       op_din_r;
    logic [1:0] op_mask_s;

    logic       gnt1_r, gnt2_r, ack1_r, ack2_r, busy_r;
    logic       gnt1_s, gnt2_s, ack1_s, ack2_s, busy_s;
    logic [1:0] s_n_r, r_n_r, d_r, clk_en_r, q_r;
    logic [1:0] s_n_s, r_n_s, d_s, clk_en_s, q_s;

    // next-state logic: a fixed four-step walk once a request is seen
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (req1 || req2) begin
                    state_s = GRANT;
                end else begin
                    state_s = IDLE;
                end
            end
            GRANT:   state_s = DRIVE;
            DRIVE:   state_s = DONE;
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // arbitration: ptr only matters when both request (0 = requester 1)
    always_comb begin
        arb_s = 1'b0;
        if (req1 && req2) begin
            arb_s = ptr_r;
        end else if (req2) begin
            arb_s = 1'b1;
        end else begin
            arb_s = 1'b0;
        end
        if (state_r == IDLE) begin
            owner_s = arb_s;
        end else begin
            owner_s = win_r;
        end
    end

    // next values of every registered output, derived from the next state
    always_comb begin
        op_mask_s = sel_mask(op_sel_r);
        gnt1_s    = 1'b0;
        gnt2_s    = 1'b0;
        ack1_s    = 1'b0;
        ack2_s    = 1'b0;
        s_n_s     = 2'b11;
        r_n_s     = 2'b11;
        d_s       = 2'b00;
        clk_en_s  = 2'b00;
        q_s       = q_r;
        ptr_s     = ptr_r;
        busy_s    = (state_s != IDLE);
        if (state_s != IDLE) begin
            gnt1_s = ~owner_s;
            gnt2_s = owner_s;
        end else begin
            gnt1_s = 1'b0;
            gnt2_s = 1'b0;
        end
        case (state_s)
            DRIVE: begin
                case (op_cmd_r)
                    CMD_SET:  s_n_s = ~op_mask_s;
                    CMD_CLR:  r_n_s = ~op_mask_s;
                    CMD_LOAD: begin
                        d_s      = {2{op_din_r}} & op_mask_s;
                        clk_en_s = op_mask_s;
                    end
                    CMD_NOP:  s_n_s = 2'b11;
                    default:  s_n_s = 2'b11;
                endcase
            end
            DONE: begin
                ack1_s = ~win_r;
                ack2_s = win_r;
                ptr_s  = ~win_r;
                case (op_cmd_r)
                    CMD_SET:  q_s = q_r | op_mask_s;
                    CMD_CLR:  q_s = q_r & ~op_mask_s;
                    CMD_LOAD: q_s = op_din_r ? (q_r | op_mask_s) : (q_r & ~op_mask_s);
                    CMD_NOP:  q_s = q_r;
                    default:  q_s = q_r;
                endcase
            end
            default: begin
                q_s = q_r;
            end
        endcase
    end

    // state, latched operation and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            ptr_r    <= 1'b0;
            win_r    <= 1'b0;
            op_cmd_r <= CMD_NOP;
            op_sel_r <= 1'b0;
            op_din_r <= 1'b0;
            gnt1_r   <= 1'b0;
            gnt2_r   <= 1'b0;
            ack1_r   <= 1'b0;
            ack2_r   <= 1'b0;
            busy_r   <= 1'b0;
            s_n_r    <= 2'b11;
            r_n_r    <= 2'b11;
            d_r      <= 2'b00;
            clk_en_r <= 2'b00;
            q_r      <= 2'b00;
        end else begin
            state_r <= state_s;
            ptr_r   <= ptr_s;
            if ((state_r == IDLE) && (state_s == GRANT)) begin
                win_r    <= arb_s;
                op_cmd_r <= arb_s ? cmd2 : cmd1;
                op_sel_r <= arb_s ? sel2 : sel1;
                op_din_r <= arb_s ? din2 : din1;
            end
            gnt1_r   <= gnt1_s;
            gnt2_r   <= gnt2_s;
            ack1_r   <= ack1_s;
            ack2_r   <= ack2_s;
            busy_r   <= busy_s;
            s_n_r    <= s_n_s;
            r_n_r    <= r_n_s;
            d_r      <= d_s;
            clk_en_r <= clk_en_s;
            q_r      <= q_s;
        end
    end

    assign gnt1   = gnt1_r;
    assign gnt2   = gnt2_r;
    assign ack1   = ack1_r;
    assign ack2   = ack2_r;
    assign busy   = busy_r;
    assign s_n    = s_n_r;
    assign r_n    = r_n_r;
    assign d      = d_r;
    assign clk_en = clk_en_r;
    assign q      = q_r;

endmodule

// File: tb/tb_hc74_arbiter.sv
// Self-checking bench for hc74_arbiter: vector table, corner-case sequences,
// and random traffic against a transaction-level reference model.
module tb_hc74_arbiter;

    typedef struct packed {
        logic       rst;
        logic       req1;
        logic       req2;
        logic [1:0] cmd1;
        logic       sel1;
        logic       din1;
        logic [1:0] cmd2;
        logic       sel2;
        logic       din2;
    } in_t;

    typedef struct packed {
        in_t         in;
        logic [14:0] exp;
    } vec_t;

    logic       clk;
    logic       rst, req1, req2, sel1, sel2, din1, din2;
    logic [1:0] cmd1, cmd2;
    logic       gnt1, gnt2, ack1, ack2, busy;
    logic [1:0] s_n, r_n, d, clk_en, q;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // reference model: one operation scheduled from the edge its request was taken
    bit         m_active = 1'b0;
    int         m_t0     = 0;
    bit         m_win    = 1'b0;
    logic [1:0] m_cmd    = 2'b00;
    bit         m_sel    = 1'b0;
    bit         m_din    = 1'b0;
    bit         m_ptr    = 1'b0;
    logic [1:0] m_q      = 2'b00;

    logic [14:0] obs, mexp;
    bit          chk_on = 1'b0;

    hc74_arbiter dut (
        .clk(clk), .rst(rst), .req1(req1), .req2(req2),
        .cmd1(cmd1), .cmd2(cmd2), .sel1(sel1), .sel2(sel2),
        .din1(din1), .din2(din2), .gnt1(gnt1), .gnt2(gnt2),
        .ack1(ack1), .ack2(ack2), .s_n(s_n), .r_n(r_n), .d(d),
        .clk_en(clk_en), .q(q), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic in_t mk(input logic r, input logic r1, input logic r2,
                               input logic [1:0] c1, input logic s1, input logic d1,
                               input logic [1:0] c2, input logic s2, input logic d2);
        in_t v;
        v = '{rst: r, req1: r1, req2: r2, cmd1: c1, sel1: s1, din1: d1,
              cmd2: c2, sel2: s2, din2: d2};
        return v;
    endfunction

    function automatic logic [14:0] ex(input logic g1, input logic g2, input logic a1,
                                       input logic a2, input logic b, input logic [1:0] sn,
                                       input logic [1:0] rn, input logic [1:0] dd,
                                       input logic [1:0] ce, input logic [1:0] qq);
        return {g1, g2, a1, a2, b, sn, rn, dd, ce, qq};
    endfunction

    function automatic logic [14:0] model_exp();
        int         age;
        logic [1:0] m, sn, rn, dd, ce;
        age = cyc - m_t0;
        m   = m_sel ? 2'b10 : 2'b01;
        sn  = 2'b11;
        rn  = 2'b11;
        dd  = 2'b00;
        ce  = 2'b00;
        if (m_active && age == 1) begin
            if (m_cmd == 2'b01) sn = 2'b11 ^ m;
            if (m_cmd == 2'b10) rn = 2'b11 ^ m;
            if (m_cmd == 2'b11) begin
                ce = m;
                dd = m_din ? m : 2'b00;
            end
        end
        return {m_active && !m_win, m_active && m_win,
                m_active && age == 2 && !m_win, m_active && age == 2 && m_win,
                m_active, sn, rn, dd, ce, m_q};
    endfunction

    task automatic model_step(input in_t v);
        cyc++;
        if (v.rst) begin
            m_active = 1'b0;
            m_ptr    = 1'b0;
            m_q      = 2'b00;
        end else if (m_active && (cyc - m_t0) == 3) begin
            m_active = 1'b0;
        end else if (!m_active && (v.req1 || v.req2)) begin
            m_win    = (v.req1 && v.req2) ? m_ptr : v.req2;
            m_cmd    = m_win ? v.cmd2 : v.cmd1;
            m_sel    = m_win ? v.sel2 : v.sel1;
            m_din    = m_win ? v.din2 : v.din1;
            m_t0     = cyc;
            m_active = 1'b1;
        end
        if (m_active && (cyc - m_t0) == 2) begin
            case (m_cmd)
                2'b01:   m_q[m_sel] = 1'b1;
                2'b10:   m_q[m_sel] = 1'b0;
                2'b11:   m_q[m_sel] = m_din;
                default: m_q = m_q;
            endcase
            m_ptr = !m_win;
        end
    endtask

    task automatic check(input string name, input logic [14:0] got, input logic [14:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, got, want);
        end
    endtask

    task automatic tick(input in_t v);
        @(negedge clk);
        rst  = v.rst;  req1 = v.req1; req2 = v.req2;
        cmd1 = v.cmd1; sel1 = v.sel1; din1 = v.din1;
        cmd2 = v.cmd2; sel2 = v.sel2; din2 = v.din2;
        @(posedge clk);
        #1;
        model_step(v);
        obs  = {gnt1, gnt2, ack1, ack2, busy, s_n, r_n, d, clk_en, q};
        mexp = model_exp();
        check("model", obs, mexp);
        if (chk_on) begin
            total++;
            if (((~s_n & ~r_n) != 2'b00) || (gnt1 && gnt2)) begin
                bad++;
                $display("FAIL excl cyc=%0d s_n=%b r_n=%b gnt1=%b gnt2=%b", cyc, s_n, r_n, gnt1, gnt2);
            end
        end
        chk_on = 1'b1;
    endtask

    vec_t tbl[17];
    in_t  v;
    in_t  rst_v;
    in_t  idle_v;

    initial begin
        int a1, a2;
        int order[$];
        bit prev_g;

        rst = 1'b1; req1 = 1'b0; req2 = 1'b0; cmd1 = 2'b00; cmd2 = 2'b00;
        sel1 = 1'b0; sel2 = 1'b0; din1 = 1'b0; din2 = 1'b0;
        rst_v  = mk(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        idle_v = mk(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);

        // SET FF2, LOAD FF1 with Din toggled after grant, CLEAR FF2, then a NOP
        tbl[0]  = '{rst_v,  ex(0, 0, 0, 0, 0, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00)};
        tbl[1]  = '{mk(0, 1, 0, 2'b01, 1, 0, 2'b00, 0, 0), ex(1, 0, 0, 0, 1, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00)};
        tbl[2]  = '{mk(0, 1, 0, 2'b01, 1, 0, 2'b00, 0, 0), ex(1, 0, 0, 0, 1, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00)};
        tbl[3]  = '{idle_v, ex(1, 0, 1, 0, 1, 2'b11, 2'b11, 2'b00, 2'b00, 2'b10)};
        tbl[4]  = '{idle_v, ex(0, 0, 0, 0, 0, 2'b11, 2'b11, 2'b00, 2'b00, 2'b10)};
        tbl[5]  = '{mk(0, 0, 1, 2'b00, 0, 0, 2'b11, 0, 1), ex(0, 1, 0, 0, 1, 2'b11, 2'b11, 2'b00, 2'b00, 2'b10)};
        tbl[6]  = '{mk(0, 0, 1, 2'b00, 0, 0, 2'b11, 0, 0), ex(0, 1, 0, 0, 1, 2'b11, 2'b11, 2'b01, 2'b01, 2'b10)};
        tbl[7]  = '{idle_v, ex(0, 1, 0, 1, 1, 2'b11, 2'b11, 2'b00, 2'b00, 2'b11)};
        tbl[8]  = '{idle_v, ex(0, 0, 0, 0, 0, 2'b11, 2'b11, 2'b00, 2'b00, 2'b11)};
        tbl[9]  = '{mk(0, 1, 0, 2'b10, 1, 0, 2'b00, 0, 0), ex(1, 0, 0, 0, 1, 2'b11, 2'b11, 2'b00, 2'b00, 2'b11)};
        tbl[10] = '{mk(0, 1, 0, 2'b10, 1, 0, 2'b00, 0, 0), ex(1, 0, 0, 0, 1, 2'b11, 2'b01, 2'b00, 2'b00, 2'b11)};
        tbl[11] = '{idle_v, ex(1, 0, 1, 0, 1, 2'b11, 2'b11, 2'b00, 2'b00, 2'b01)};
        tbl[12] = '{idle_v, ex(0, 0, 0, 0, 0, 2'b11, 2'b11, 2'b00, 2'b00, 2'b01)};
        tbl[13] = '{mk(0, 0, 1, 2'b00, 0, 0, 2'b00, 1, 1), ex(0, 1, 0, 0, 1, 2'b11, 2'b11, 2'b00, 2'b00, 2'b01)};
        tbl[14] = '{idle_v, ex(0, 1, 0, 0, 1, 2'b11, 2'b11, 2'b00, 2'b00, 2'b01)};
        tbl[15] = '{idle_v, ex(0, 1, 0, 1, 1, 2'b11, 2'b11, 2'b00, 2'b00, 2'b01)};
        tbl[16] = '{idle_v, ex(0, 0, 0, 0, 0, 2'b11, 2'b11, 2'b00, 2'b00, 2'b01)};

        for (int i = 0; i < 17; i++) begin
            tick(tbl[i].in);
            check($sformatf("vec%0d", i), obs, tbl[i].exp);
        end

        // simultaneous LOAD requests right after reset: requester 1 first, Ack2 four cycles later
        tick(rst_v);
        a1 = -1;
        a2 = -1;
        for (int k = 0; k < 20; k++) begin
            tick(mk(1'b0, a1 < 0, a2 < 0, 2'b11, 1'b0, 1'b1, 2'b11, 1'b1, 1'b1));
            if (ack1 && a1 < 0) a1 = k;
            if (ack2 && a2 < 0) a2 = k;
        end
        total++;
        if (a1 != 2 || a2 != 6) begin
            bad++;
            $display("FAIL both_load ack1_at=%0d ack2_at=%0d want 2 and 6", a1, a2);
        end
        check("both_load_q", {13'd0, q}, {13'd0, 2'b11});

        // both held high: grants must alternate 1,2,1,2...
        tick(rst_v);
        prev_g = 1'b0;
        for (int k = 0; k < 60 && order.size() < 8; k++) begin
            tick(mk(1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0));
            if ((gnt1 || gnt2) && !prev_g) order.push_back(gnt2 ? 2 : 1);
            prev_g = gnt1 || gnt2;
        end
        total++;
        if (order.size() != 8) begin
            bad++;
            $display("FAIL rr_count got=%0d want=8", order.size());
        end
        for (int i = 0; i < order.size(); i++) begin
            total++;
            if (order[i] != (i % 2) + 1) begin
                bad++;
                $display("FAIL rr_order idx=%0d got=%0d want=%0d", i, order[i], (i % 2) + 1);
            end
        end

        // reset taken at the edge ending DRIVE of a CLEAR: operation abandoned
        tick(rst_v);
        for (int k = 0; k < 4; k++) tick(mk(1'b0, k < 3, 1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0));
        check("pre_clear_q", {13'd0, q}, {13'd0, 2'b01});
        tick(mk(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0));
        tick(mk(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0));
        check("clr_drive", {13'd0, r_n}, {13'd0, 2'b10});
        tick(mk(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0));
        check("rst_abort", obs, ex(0, 0, 0, 0, 0, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00));
        for (int k = 0; k < 3; k++) begin
            tick(idle_v);
            check("rst_no_ack", {13'd0, ack1, ack2}, 15'd0);
        end

        // random traffic, including occasional reset, against the model
        for (int k = 0; k < 1500; k++) begin
            v.rst  = ($urandom_range(0, 39) == 0);
            v.req1 = ($urandom_range(0, 2) != 0);
            v.req2 = ($urandom_range(0, 2) != 0);
            v.cmd1 = 2'($urandom_range(0, 3));
            v.cmd2 = 2'($urandom_range(0, 3));
            v.sel1 = 1'($urandom_range(0, 1));
            v.sel2 = 1'($urandom_range(0, 1));
            v.din1 = 1'($urandom_range(0, 1));
            v.din2 = 1'($urandom_range(0, 1));
            tick(v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
